// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Sequences a multi-cycle datapath through one instruction at a time over
//   a single shared memory bus: instruction fetch, one decode cycle, an
//   optional load/store, then a one-cycle commit strobe to the datapath.
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   active                 high while running (FETCH..COMMIT)
//   clk_enable             one-cycle commit strobe to datapath state
//   instr_address          fetch address (datapath PC)
//   instr_readdata         latched instruction word
//   data_read, data_write  load / store request for current instruction
//   data_byteenable        byte lanes for the data access
//   data_address           load/store address
//   data_writedata         store data
//   data_readdata          latched load data
//   bus_*                  memory bus master (address, strobes, lanes, data,
//                          waitrequest stall, readdata)
module mem_access_sequencer #(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic        clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t        state, state_n;

  // Data access captured when leaving DECODE, held for the whole DATA phase
  logic          acc_store;
  logic [AW-1:0] acc_addr;
  logic [BW-1:0] acc_be;
  logic [DW-1:0] acc_wdata;

  logic          halt_hit;
  logic          fetch_done;
  logic          load_done;
  logic          decode_acc;

  assign halt_hit   = (instr_address == HALT_ADDR);
  assign fetch_done = (state == S_FETCH) && !halt_hit && !bus_waitrequest;
  assign load_done  = (state == S_DATA) && !acc_store && !bus_waitrequest;
  assign decode_acc = (state == S_DECODE) && (data_read || data_write);

  // State register and data latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_RST;
      acc_store      <= 1'b0;
      acc_addr       <= '0;
      acc_be         <= '0;
      acc_wdata      <= '0;
      instr_readdata <= '0;
      data_readdata  <= '0;
    end else begin
      state <= state_n;
      if (fetch_done) begin
        instr_readdata <= bus_readdata;
      end
      // Store wins when both requests are raised together
      if (decode_acc) begin
        acc_store <= data_write;
        acc_addr  <= data_address;
        acc_be    <= data_byteenable;
        acc_wdata <= data_write ? data_writedata : DW'(0);
      end
      if (load_done) begin
        data_readdata <= bus_readdata;
      end
    end
  end

  // Next state and bus outputs. Bus outputs decode from the registered state
  // so the fetch read can start in the same cycle the committed PC appears.
  always_comb begin
    state_n        = state;
    active         = 1'b0;
    clk_enable     = 1'b0;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_address    = '0;
    bus_byteenable = '0;
    bus_writedata  = '0;

    case (state)
      S_RST: begin
        state_n = S_FETCH;
      end

      S_FETCH: begin
        active = 1'b1;
        if (halt_hit) begin
          state_n = S_HALT;
        end else begin
          bus_read       = 1'b1;
          bus_address    = instr_address;
          bus_byteenable = BW'(4'b1111);
          if (!bus_waitrequest) begin
            state_n = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        active = 1'b1;
        if (data_write || data_read) begin
          state_n = S_DATA;
        end else begin
          state_n = S_COMMIT;
        end
      end

      S_DATA: begin
        active         = 1'b1;
        bus_address    = acc_addr;
        bus_byteenable = acc_be;
        if (acc_store) begin
          bus_write     = 1'b1;
          bus_writedata = acc_wdata;
        end else begin
          bus_read = 1'b1;
        end
        if (!bus_waitrequest) begin
          state_n = S_COMMIT;
        end
      end

      S_COMMIT: begin
        active     = 1'b1;
        clk_enable = 1'b1;
        state_n    = S_FETCH;
      end

      S_HALT: begin
        state_n = S_HALT;
      end

      default: begin
        state_n = S_HALT;
      end
    endcase
  end

endmodule
